// File: rtl/gx4000_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gx4000_pkg
//  Description : Shared types and constants for the GX4000 sprite scheduler:
//                scheduler state encoding, sprite/slot counts and the sprite
//                RAM address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package gx4000_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int NUM_SPRITES  = 16;
    localparam int MAX_PER_LINE = 8;
    localparam int RAM_AW       = 12;

endpackage
`default_nettype wire

// File: rtl/gx4000_sprite_hit_test.sv
`default_nettype none
// ============================================================================
//  Module      : gx4000_sprite_hit_test
//  Description : Combinational vertical hit test for one sprite. The sprite
//                covers 16 << (mag-1) lines starting at attr_y, wrapping
//                modulo 512; row is the source row within the 16-row sprite.
//  Ports       : i_vpos     - line being prepared
//                i_attr_y   - sprite top line
//                i_attr_mag - 0 disabled, 1/2/3 = x1/x2/x4
//                o_hit      - sprite covers i_vpos
//                o_row      - 4-bit source row when o_hit
//  Revision    : 1.0 - initial release
// ============================================================================
module gx4000_sprite_hit_test (
    input  logic [8:0] i_vpos,
    input  logic [8:0] i_attr_y,
    input  logic [1:0] i_attr_mag,
    output logic       o_hit,
    output logic [3:0] o_row
);

    // Modulo-512 distance; a sprite near the bottom wraps onto the top lines.
    logic [8:0] w_d;
    assign w_d = i_vpos - i_attr_y;

    always_comb begin
        o_hit = 1'b0;
        o_row = 4'h0;
        case (i_attr_mag)
            2'd1: begin
                o_hit = (w_d[8:4] == 5'd0);
                o_row = w_d[3:0];
            end
            2'd2: begin
                o_hit = (w_d[8:5] == 4'd0);
                o_row = w_d[4:1];
            end
            2'd3: begin
                o_hit = (w_d[8:6] == 3'd0);
                o_row = w_d[5:2];
            end
            default: begin
                o_hit = 1'b0;
                o_row = 4'h0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/gx4000_sprite_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : gx4000_sprite_scheduler
//  Description : Per-line sprite scheduler. At hblank start it scans all
//                sprite attributes (one per cycle), records the first
//                MAX_PER_LINE sprites covering vpos, then fetches 16 pixels
//                of each recorded sprite row from sprite RAM into the line
//                buffer. The CPU has priority on the RAM and simply stalls
//                the fetch.
//  Ports       : clk_sys, reset_n (async, active-low)
//                plus_mode, line_start, vpos       - line control
//                attr_idx / attr_y / attr_mag      - attribute lookup
//                ram_addr / ram_rdata              - sprite RAM (1-cycle read)
//                cpu_req / cpu_addr / cpu_gnt      - CPU RAM arbitration
//                lb_we/lb_slot/lb_sprite/lb_col/lb_data - line-buffer writes
//                line_ready                        - fetch complete pulse
//                status / status_clr               - sticky overflow/overrun
//  Revision    : 1.0 - initial release
// ============================================================================
module gx4000_sprite_scheduler
    import gx4000_pkg::*;
#(
    parameter int MAX_PER_LINE = 8,
    parameter int NUM_SPRITES  = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        plus_mode,
    input  logic        line_start,
    input  logic [8:0]  vpos,
    output logic [3:0]  attr_idx,
    input  logic [8:0]  attr_y,
    input  logic [1:0]  attr_mag,
    output logic [11:0] ram_addr,
    input  logic [3:0]  ram_rdata,
    input  logic        cpu_req,
    input  logic [11:0] cpu_addr,
    output logic        cpu_gnt,
    output logic        lb_we,
    output logic [2:0]  lb_slot,
    output logic [3:0]  lb_sprite,
    output logic [3:0]  lb_col,
    output logic [3:0]  lb_data,
    output logic        line_ready,
    output logic [1:0]  status,
    input  logic        status_clr
);

    localparam logic [3:0] c_MAX_HITS = 4'(MAX_PER_LINE);
    localparam logic [3:0] c_LAST_IDX = 4'(NUM_SPRITES - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_idx;
    logic [3:0]  r_hit_cnt;
    logic [3:0]  r_tbl_spr [MAX_PER_LINE];
    logic [3:0]  r_tbl_row [MAX_PER_LINE];
    logic [2:0]  r_slot;
    logic [3:0]  r_col;

    logic        r_lb_we;
    logic [2:0]  r_lb_slot;
    logic [3:0]  r_lb_sprite;
    logic [3:0]  r_lb_col;
    logic        r_line_ready;
    logic [1:0]  r_status;

    logic        w_hit;
    logic [3:0]  w_row;
    logic        w_busy;
    logic        w_restart;
    logic        w_scanning;
    logic        w_scan_last;
    logic        w_record;
    logic        w_overflow;
    logic [3:0]  w_hit_cnt_nxt;
    logic        w_issue;
    logic        w_last_read;
    logic [11:0] w_fetch_addr;
    logic [1:0]  w_status_nxt;

    gx4000_sprite_hit_test u_hit_test (
        .i_vpos     (vpos),
        .i_attr_y   (attr_y),
        .i_attr_mag (attr_mag),
        .o_hit      (w_hit),
        .o_row      (w_row)
    );

    assign w_busy        = (r_state != ST_IDLE);
    assign w_restart     = line_start & plus_mode;
    assign w_scanning    = (r_state == ST_SCAN);
    assign w_scan_last   = w_scanning & (r_idx == c_LAST_IDX);
    assign w_record      = w_scanning & w_hit & (r_hit_cnt < c_MAX_HITS);
    assign w_overflow    = w_scanning & w_hit & (r_hit_cnt >= c_MAX_HITS);
    assign w_hit_cnt_nxt = r_hit_cnt + {3'b000, w_record};

    // A fetch read happens on every FETCH cycle the CPU does not claim.
    assign w_issue       = (r_state == ST_FETCH) & ~cpu_req;
    assign w_last_read   = w_issue & (r_col == 4'hF) &
                           (({1'b0, r_slot} + 4'd1) == r_hit_cnt);
    assign w_fetch_addr  = {r_tbl_spr[r_slot], r_tbl_row[r_slot], r_col};

    // Set beats clear when both happen in the same cycle.
    assign w_status_nxt  = (status_clr ? 2'b00 : r_status) |
                           {line_start & w_busy, w_overflow};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!plus_mode) begin
            w_state_nxt = ST_IDLE;
        end else if (line_start) begin
            // Start from IDLE, or abort-and-restart from any busy state.
            w_state_nxt = ST_SCAN;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_IDLE;
                ST_SCAN:  if (w_scan_last) begin
                              w_state_nxt = (w_hit_cnt_nxt == 4'd0) ? ST_DONE : ST_FETCH;
                          end
                ST_FETCH: if (w_last_read) begin
                              w_state_nxt = ST_DONE;
                          end
                ST_DONE:  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Scan index, hit table and fetch pointers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_idx     <= 4'h0;
            r_hit_cnt <= 4'h0;
            r_slot    <= 3'h0;
            r_col     <= 4'h0;
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                r_tbl_spr[i] <= 4'h0;
                r_tbl_row[i] <= 4'h0;
            end
        end else if (w_restart) begin
            r_idx     <= 4'h0;
            r_hit_cnt <= 4'h0;
            r_slot    <= 3'h0;
            r_col     <= 4'h0;
        end else begin
            if (w_scanning) begin
                r_idx <= w_scan_last ? 4'h0 : r_idx + 4'd1;
            end
            if (w_record) begin
                r_tbl_spr[r_hit_cnt[2:0]] <= r_idx;
                r_tbl_row[r_hit_cnt[2:0]] <= w_row;
                r_hit_cnt                 <= w_hit_cnt_nxt;
            end
            if (w_issue) begin
                r_col <= r_col + 4'd1;
                if (r_col == 4'hF) begin
                    r_slot <= r_slot + 3'd1;
                end
            end
        end
    end

    // Line-buffer write stage: tags the read issued last cycle, whose data
    // arrives on ram_rdata this cycle. Not gated by restart so an in-flight
    // read still lands.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_lb_we      <= 1'b0;
            r_lb_slot    <= 3'h0;
            r_lb_sprite  <= 4'h0;
            r_lb_col     <= 4'h0;
            r_line_ready <= 1'b0;
            r_status     <= 2'b00;
        end else begin
            r_lb_we <= w_issue;
            if (w_issue) begin
                r_lb_slot   <= r_slot;
                r_lb_sprite <= r_tbl_spr[r_slot];
                r_lb_col    <= r_col;
            end
            // A line_start or plus_mode drop during DONE cancels the pulse.
            r_line_ready <= (r_state == ST_DONE) & plus_mode & ~line_start;
            r_status     <= w_status_nxt;
        end
    end

    assign attr_idx   = r_idx;
    assign cpu_gnt    = cpu_req;
    assign ram_addr   = cpu_req ? cpu_addr :
                        ((r_state == ST_FETCH) ? w_fetch_addr : 12'h000);
    assign lb_we      = r_lb_we;
    assign lb_slot    = r_lb_slot;
    assign lb_sprite  = r_lb_sprite;
    assign lb_col     = r_lb_col;
    assign lb_data    = r_lb_we ? ram_rdata : 4'h0;
    assign line_ready = r_line_ready;
    assign status     = r_status;

endmodule
`default_nettype wire

// File: tb/tb_gx4000_sprite_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gx4000_sprite_scheduler
//  Description : Directed self-checking bench for gx4000_sprite_scheduler.
//                Drives an attribute table and a 1-cycle-latency sprite RAM
//                model, logs every line-buffer write, and compares against
//                hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gx4000_sprite_scheduler;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        plus_mode;
    logic        line_start;
    logic [8:0]  vpos;
    logic [3:0]  attr_idx;
    logic [8:0]  attr_y;
    logic [1:0]  attr_mag;
    logic [11:0] ram_addr;
    logic [3:0]  ram_rdata = 4'h0;
    logic        cpu_req;
    logic [11:0] cpu_addr;
    logic        cpu_gnt;
    logic        lb_we;
    logic [2:0]  lb_slot;
    logic [3:0]  lb_sprite;
    logic [3:0]  lb_col;
    logic [3:0]  lb_data;
    logic        line_ready;
    logic [1:0]  status;
    logic        status_clr;

    logic [8:0]  spr_y   [16];
    logic [1:0]  spr_mag [16];
    logic [3:0]  exp_spr [8];
    logic [3:0]  exp_row [8];
    int          hit_list [10] = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14};

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          we_cnt = 0;
    int          rdy_cnt = 0;
    int          rdy_cyc = 0;
    int          gnt_cnt = 0;
    int          gnt_bad = 0;
    logic [11:0] prev_addr = 12'h000;
    logic [26:0] ev [1024];

    gx4000_sprite_scheduler #(
        .MAX_PER_LINE (8),
        .NUM_SPRITES  (16)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .plus_mode  (plus_mode),
        .line_start (line_start),
        .vpos       (vpos),
        .attr_idx   (attr_idx),
        .attr_y     (attr_y),
        .attr_mag   (attr_mag),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .lb_we      (lb_we),
        .lb_slot    (lb_slot),
        .lb_sprite  (lb_sprite),
        .lb_col     (lb_col),
        .lb_data    (lb_data),
        .line_ready (line_ready),
        .status     (status),
        .status_clr (status_clr)
    );

    always #5 clk_sys = ~clk_sys;

    assign attr_y   = spr_y[attr_idx];
    assign attr_mag = spr_mag[attr_idx];

    function automatic logic [3:0] mem_f(input logic [11:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'h5;
    endfunction

    always @(posedge clk_sys) begin
        cyc       <= cyc + 1;
        ram_rdata <= mem_f(ram_addr);
    end

    // Log line-buffer writes with the address presented one cycle earlier.
    always @(negedge clk_sys) begin
        if (lb_we) begin
            ev[we_cnt % 1024] = {lb_slot, lb_sprite, lb_col, prev_addr, lb_data};
            we_cnt++;
        end
        if (line_ready) begin
            rdy_cnt++;
            rdy_cyc = cyc;
        end
        if (cpu_gnt) begin
            gnt_cnt++;
            if (ram_addr != cpu_addr) gnt_bad++;
        end
        prev_addr = ram_addr;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_spr();
        for (int i = 0; i < 16; i++) begin
            spr_y[i]   = 9'd0;
            spr_mag[i] = 2'd0;
        end
    endtask

    task automatic start_line(input logic [8:0] v);
        vpos       = v;
        line_start = 1'b1;
        start_cyc  = cyc;
        tick(1);
        line_start = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int exp_lat);
        int r0;
        int n;
        r0 = rdy_cnt;
        n  = 0;
        while (rdy_cnt == r0 && n < 400) begin
            tick(1);
            n++;
        end
        check_vec({tag, " ready"}, rdy_cnt - r0, 1);
        check_vec({tag, " latency"}, rdy_cyc - start_cyc, exp_lat);
    endtask

    task automatic chk_fetch(input string tag, input int base, input int h);
        check_vec({tag, " we count"}, we_cnt - base, 16 * h);
        for (int k = 0; k < h; k++) begin
            for (int c = 0; c < 16; c++) begin
                logic [11:0] a;
                a = {exp_spr[k], exp_row[k], 4'(c)};
                check_vec($sformatf("%s ev k%0d c%0d", tag, k, c),
                          {5'b0, ev[(base + k * 16 + c) % 1024]},
                          {5'b0, 3'(k), exp_spr[k], 4'(c), a, mem_f(a)});
            end
        end
    endtask

    task automatic setup_single();
        clear_spr();
        spr_y[3]   = 9'd100;
        spr_mag[3] = 2'd1;
        exp_spr[0] = 4'd3;
        exp_row[0] = 4'd7;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int r0;
        int g0;

        reset_n    = 1'b0;
        plus_mode  = 1'b1;
        line_start = 1'b0;
        vpos       = 9'd0;
        cpu_req    = 1'b0;
        cpu_addr   = 12'h000;
        status_clr = 1'b0;
        clear_spr();
        tick(3);

        // Reset state
        check_vec("rst attr_idx", attr_idx, 0);
        check_vec("rst ram_addr", ram_addr, 0);
        check_vec("rst lb_we", lb_we, 0);
        check_vec("rst lb fields", {lb_slot, lb_sprite, lb_col, lb_data}, 0);
        check_vec("rst line_ready", line_ready, 0);
        check_vec("rst status", status, 0);

        // Single mag1 sprite; line_start on the first edge after reset release
        setup_single();
        base    = we_cnt;
        reset_n = 1'b1;
        start_line(9'd107);
        tick(5);
        check_vec("t1 attr_idx", attr_idx, 5);
        wait_ready("t1", 34);
        chk_fetch("t1", base, 1);
        check_vec("t1 status", status, 0);

        // No hits: SCAN straight to DONE
        clear_spr();
        base = we_cnt;
        tick(2);
        start_line(9'd107);
        wait_ready("t0hit", 18);
        check_vec("t0hit we count", we_cnt - base, 0);

        // Ten hits, only the lowest eight indices are fetched
        clear_spr();
        for (int i = 0; i < 10; i++) begin
            spr_y[hit_list[i]]   = 9'(50 - hit_list[i]);
            spr_mag[hit_list[i]] = 2'd1;
        end
        for (int k = 0; k < 8; k++) begin
            exp_spr[k] = 4'(hit_list[k]);
            exp_row[k] = 4'(hit_list[k]);
        end
        base = we_cnt;
        tick(2);
        start_line(9'd50);
        wait_ready("t2", 146);
        chk_fetch("t2", base, 8);
        check_vec("t2 status", status, 2'b01);
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
        check_vec("t2 status clr", status, 2'b00);

        // Wrap-around and magnification boundaries
        clear_spr();
        spr_y[0]  = 9'd500; spr_mag[0]  = 2'd2;   // d=17 -> row 8
        spr_y[6]  = 9'd6;   spr_mag[6]  = 2'd1;   // d=511 -> miss
        spr_y[9]  = 9'd501; spr_mag[9]  = 2'd1;   // d=16 -> miss at x1
        spr_y[12] = 9'd454; spr_mag[12] = 2'd3;   // d=63 -> row 15
        exp_spr[0] = 4'd0;  exp_row[0] = 4'd8;
        exp_spr[1] = 4'd12; exp_row[1] = 4'd15;
        base = we_cnt;
        tick(2);
        start_line(9'd5);
        wait_ready("t3", 50);
        chk_fetch("t3", base, 2);
        check_vec("t3 status", status, 0);

        // CPU steals five FETCH cycles
        setup_single();
        base = we_cnt;
        tick(2);
        start_line(9'd107);
        tick(19);
        g0       = gnt_cnt;
        cpu_addr = 12'hABC;
        cpu_req  = 1'b1;
        tick(5);
        cpu_req  = 1'b0;
        wait_ready("t4", 39);
        check_vec("t4 gnt cycles", gnt_cnt - g0, 5);
        check_vec("t4 gnt addr", gnt_bad, 0);
        chk_fetch("t4", base, 1);

        // line_start during FETCH with a coincident status_clr
        setup_single();
        r0 = rdy_cnt;
        tick(2);
        start_line(9'd107);
        tick(23);
        line_start = 1'b1;
        status_clr = 1'b1;
        start_cyc  = cyc;
        tick(1);
        line_start = 1'b0;
        status_clr = 1'b0;
        check_vec("t5 status", status, 2'b10);
        check_vec("t5 inflight we", lb_we, 1);
        check_vec("t5 inflight col", lb_col, 7);
        tick(1);
        check_vec("t5 rescan idx", attr_idx, 1);
        base = we_cnt;
        wait_ready("t5", 34);
        check_vec("t5 ready total", rdy_cnt - r0, 1);
        chk_fetch("t5", base, 1);
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
        check_vec("t5 status clr", status, 2'b00);

        // Asynchronous reset mid-FETCH
        setup_single();
        tick(2);
        start_line(9'd107);
        tick(3);
        start_line(9'd107);
        tick(21);
        check_vec("t6 status pre", status, 2'b10);
        r0 = rdy_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("t6 attr_idx", attr_idx, 0);
        check_vec("t6 ram_addr", ram_addr, 0);
        check_vec("t6 lb", {lb_we, lb_slot, lb_sprite, lb_col, lb_data}, 0);
        check_vec("t6 ready/gnt", {line_ready, cpu_gnt}, 0);
        check_vec("t6 status", status, 0);
        tick(3);
        reset_n = 1'b1;
        tick(40);
        check_vec("t6 no ready", rdy_cnt - r0, 0);

        // plus_mode drop mid-FETCH, and line_start ignored while low
        setup_single();
        r0 = rdy_cnt;
        start_line(9'd107);
        tick(19);
        plus_mode = 1'b0;
        tick(1);
        check_vec("t7 ram_addr idle", ram_addr, 0);
        plus_mode = 1'b1;
        tick(40);
        check_vec("t7 no ready", rdy_cnt - r0, 0);
        plus_mode = 1'b0;
        start_line(9'd107);
        tick(5);
        check_vec("t7 idle idx", attr_idx, 0);
        tick(40);
        check_vec("t7 no ready off", rdy_cnt - r0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gx4000_sprite_scheduler.md
GX4000_SPRITE_SCHEDULER -- requirements
Module: gx4000_sprite_scheduler

Interface
REQ-001 Parameter MAX_PER_LINE, default 8: maximum sprites fetched per scan line.
REQ-002 Parameter NUM_SPRITES, default 16: number of hardware sprites scanned.
REQ-003 Port clk_sys, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port plus_mode, input, 1 bit: enable; when low the block holds IDLE and issues no RAM reads.
REQ-006 Port line_start, input, 1 bit: one-cycle pulse at hblank start.
REQ-007 Port vpos, input, 9 bits: line to be prepared.
REQ-008 Port attr_idx, output, 4 bits: attribute read index.
REQ-009 Port attr_y, input, 9 bits: combinational Y of sprite attr_idx.
REQ-010 Port attr_mag, input, 2 bits: combinational Y magnification of sprite attr_idx; 0 means disabled, 1/2/3 mean x1/x2/x4.
REQ-011 Port ram_addr, output, 12 bits: sprite RAM address, {idx,row,col}.
REQ-012 Port ram_rdata, input, 4 bits: pixel data, valid 1 cycle after ram_addr.
REQ-013 Port cpu_req, input, 1 bit: CPU RAM access request.
REQ-014 Port cpu_addr, input, 12 bits: CPU RAM address.
REQ-015 Port cpu_gnt, output, 1 bit: CPU owns the RAM this cycle.
REQ-016 Port lb_we, output, 1 bit: line-buffer write strobe.
REQ-017 Port lb_slot, output, 3 bits: line-buffer slot (0 = highest priority).
REQ-018 Port lb_sprite, output, 4 bits: sprite index written to the slot.
REQ-019 Port lb_col, output, 4 bits: pixel column.
REQ-020 Port lb_data, output, 4 bits: pixel value.
REQ-021 Port line_ready, output, 1 bit: one-cycle pulse when fetch is complete.
REQ-022 Port status, output, 2 bits: sticky flags; bit0 = more than MAX_PER_LINE hits, bit1 = line_start arrived while busy.
REQ-023 Port status_clr, input, 1 bit: clears status.

Function
REQ-024 States: IDLE, SCAN, FETCH, DONE.
REQ-025 Transitions: IDLE->SCAN on line_start with plus_mode; SCAN->FETCH after index NUM_SPRITES-1; FETCH->DONE after the last column of the last hit; DONE->IDLE after one cycle.
REQ-026 SCAN: one index per cycle, 0 to 15; attr_idx equals the index under test.
REQ-027 Hit test: mag!=0 and d=(vpos-attr_y) mod 512 satisfies d < 16<<(mag-1); row = d>>(mag-1), 4 bits.
REQ-028 The first MAX_PER_LINE hits in ascending index order are recorded with their rows; further hits set status bit0.
REQ-029 FETCH: for each recorded hit (slot k), columns 0..15 are issued in order, ram_addr={idx,row,col}, one per granted cycle.
REQ-030 Zero hits: SCAN goes directly to DONE.
REQ-031 Arbitration: cpu_req has priority; cpu_gnt=cpu_req combinationally; ram_addr=cpu_addr while granted; the fetch stalls with its column held.
REQ-032 Write pipeline: lb_we is asserted 1 cycle after each fetch-issued read, carrying that read's slot, sprite, col and ram_rdata; CPU reads produce no lb_we.
REQ-033 Latency with no CPU stalls and H hits: line_ready fires 16+16H+2 cycles after line_start.
REQ-034 line_start outside IDLE aborts the operation, sets status bit1 and restarts SCAN next cycle; the in-flight lb_we still completes.
REQ-035 status_clr coincident with a flag-setting event: the set wins.
REQ-036 plus_mode falling mid-operation forces IDLE next cycle with no line_ready.

Reset
REQ-037 reset_n low: state=IDLE; attr_idx, ram_addr, lb_slot, lb_sprite, lb_col and lb_data = 0; lb_we, line_ready and cpu_gnt-pipeline registers = 0; status = 0; hit table cleared.
REQ-038 The first line_start is accepted on the first edge after reset_n deasserts.

Structure
REQ-039 Package gx4000_pkg holds the state enum, NUM_SPRITES, MAX_PER_LINE and the RAM address width.
REQ-040 Sub-module gx4000_sprite_hit_test holds the combinational hit/row computation of REQ-027.

Verification
REQ-041 Sprite 3 at y=100 mag1, vpos=107, no CPU -> 16 lb_we, slot0, sprite3, ram_addr 0x370..0x37F; line_ready 34 cycles after line_start.
REQ-042 Ten sprites hitting -> slots 0..7 hold indices of the lowest 8 hits; status=01.
REQ-043 Sprite 0 at y=500 mag2, vpos=5 -> wrap d=17, row 8 is fetched.
REQ-044 cpu_req held 5 cycles during FETCH -> cpu_gnt high for 5 cycles, no lb_we gap errors, line_ready delayed by exactly 5 cycles.
REQ-045 line_start during FETCH -> status=10, SCAN restarts; status_clr then returns status to 00.
REQ-046 reset_n asserted mid-FETCH -> all outputs 0 asynchronously, no line_ready.
